// File: rtl/tow_pkg.sv
// Shared types and display constants for the tug-of-war match sequencer.
package tow_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    HOLD = 2'd2,
    OVER = 2'd3
  } state_t;

  localparam logic [1:0] WIN_NONE = 2'd0;
  localparam logic [1:0] WIN_P1   = 2'd1;
  localparam logic [1:0] WIN_P2   = 2'd2;

  // Active-low segments, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;

  localparam logic [6:0] SEG_DIGITS [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

  // Digit lookup; anything above 9 is shown blank
  function automatic logic [6:0] seg_lookup(input logic [3:0] value);
    logic [6:0] seg;
    seg = SEG_BLANK;
    for (int i = 0; i < 10; i++) begin
      if (value == 4'(i)) seg = SEG_DIGITS[i];
    end
    return seg;
  endfunction

endpackage

// File: rtl/tow_match_ctrl_seg7_digit.sv
// 4-bit value to active-low 7-segment pattern, blank for values above 9.
module seg7_digit
  import tow_pkg::*;
(
  input  logic [3:0] value,
  output logic [6:0] seg
);

  // Pure table decode of the score digit
  assign seg = seg_lookup(value);

endmodule

// File: rtl/tow_match_ctrl.sv
// Round/match sequencer for tug-of-war: detects round wins, keeps score,
// holds the playfield in reset between rounds and declares the match winner.
module tow_match_ctrl
  import tow_pkg::*;
#(
  parameter int WIN_TARGET  = 3,
  parameter int HOLD_CYCLES = 1024,
  parameter int CW          = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       L,
  input  logic       R,
  input  logic       lmost,
  input  logic       rmost,
  output logic       field_reset,
  output logic       press_en,
  output logic [1:0] round_winner,
  output logic       match_over,
  output logic [6:0] hex_p1,
  output logic [6:0] hex_p2,
  output logic [6:0] hex_win
);

  localparam logic [3:0]    TARGET    = 4'(WIN_TARGET);
  localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);

  state_t        state, state_n;
  logic [3:0]    score1, score1_n;
  logic [3:0]    score2, score2_n;
  logic [1:0]    winner, winner_n;
  logic [CW-1:0] cnt, cnt_n;

  logic          p1_win, p2_win;
  logic [3:0]    score1_inc, score2_inc;

  // Raw round-win conditions; contradictory presses or both ends lit never count
  assign p1_win = R & ~L & rmost & ~lmost;
  assign p2_win = L & ~R & lmost & ~rmost;

  // Saturating increments so a score can never pass the target
  assign score1_inc = (score1 < TARGET) ? score1 + 4'd1 : score1;
  assign score2_inc = (score2 < TARGET) ? score2 + 4'd1 : score2;

  // State, scores, last round winner and hold counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      score1 <= 4'd0;
      score2 <= 4'd0;
      winner <= WIN_NONE;
      cnt    <= '0;
    end else begin
      state  <= state_n;
      score1 <= score1_n;
      score2 <= score2_n;
      winner <= winner_n;
      cnt    <= cnt_n;
    end
  end

  // Next-state logic; start outranks a simultaneous win in PLAY
  always_comb begin
    state_n  = state;
    score1_n = score1;
    score2_n = score2;
    winner_n = winner;
    cnt_n    = cnt;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_n  = PLAY;
          score1_n = 4'd0;
          score2_n = 4'd0;
          winner_n = WIN_NONE;
        end
      end
      PLAY: begin
        if (start) begin
          score1_n = 4'd0;
          score2_n = 4'd0;
          winner_n = WIN_NONE;
        end else if (p1_win) begin
          score1_n = score1_inc;
          winner_n = WIN_P1;
          if (score1_inc == TARGET) begin
            state_n = OVER;
          end else begin
            state_n = HOLD;
            cnt_n   = HOLD_LOAD;
          end
        end else if (p2_win) begin
          score2_n = score2_inc;
          winner_n = WIN_P2;
          if (score2_inc == TARGET) begin
            state_n = OVER;
          end else begin
            state_n = HOLD;
            cnt_n   = HOLD_LOAD;
          end
        end
      end
      HOLD: begin
        if (cnt == '0) begin
          state_n  = PLAY;
          winner_n = WIN_NONE;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      OVER: begin
        if (start) begin
          state_n  = PLAY;
          score1_n = 4'd0;
          score2_n = 4'd0;
          winner_n = WIN_NONE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Moore outputs decoded from registered state only
  always_comb begin
    field_reset  = (state != PLAY);
    press_en     = (state == PLAY);
    match_over   = (state == OVER);
    round_winner = winner;
    case (winner)
      WIN_P1:  hex_win = SEG_1;
      WIN_P2:  hex_win = SEG_2;
      default: hex_win = SEG_BLANK;
    endcase
  end

  seg7_digit u_seg_p1 (
    .value (score1),
    .seg   (hex_p1)
  );

  seg7_digit u_seg_p2 (
    .value (score2),
    .seg   (hex_p2)
  );

endmodule

// File: tb/tb_tow_match_ctrl.sv
// Scoreboard bench for tow_match_ctrl: a match-level reference model predicts
// the outputs after every clock edge and a monitor compares them.
module tb_tow_match_ctrl;

  localparam int WIN_TARGET  = 3;
  localparam int HOLD_CYCLES = 4;
  localparam int CW          = 10;

  logic       clk = 1'b0;
  logic       reset, start, L, R, lmost, rmost;
  logic       field_reset, press_en, match_over;
  logic [1:0] round_winner;
  logic [6:0] hex_p1, hex_p2, hex_win;

  typedef struct {
    logic       fr;
    logic       pe;
    logic       mo;
    logic [1:0] rw;
    logic [6:0] h1;
    logic [6:0] h2;
    logic [6:0] hw;
  } exp_t;

  exp_t sb[$];
  exp_t got;
  int   checks   = 0;
  int   failures = 0;
  int   cycle    = 0;

  // Reference model of the match, in game terms
  bit         m_started;
  bit         m_over;
  int         m_hold_left;
  int         m_s1, m_s2;
  logic [1:0] m_last;

  tow_match_ctrl #(
    .WIN_TARGET  (WIN_TARGET),
    .HOLD_CYCLES (HOLD_CYCLES),
    .CW          (CW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .L            (L),
    .R            (R),
    .lmost        (lmost),
    .rmost        (rmost),
    .field_reset  (field_reset),
    .press_en     (press_en),
    .round_winner (round_winner),
    .match_over   (match_over),
    .hex_p1       (hex_p1),
    .hex_p2       (hex_p2),
    .hex_win      (hex_win)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] digit(input int v);
    case (v)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      default: return 7'b1111111;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [6:0] act, input logic [6:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s cycle=%0d actual=%b expected=%b", name, cycle, act, exp);
    end
  endtask

  // Advance the model by one clock edge and queue what the DUT should show
  task automatic modelStep(input bit rs, input bit st, input bit l, input bit r,
                           input bit lm, input bit rm);
    exp_t e;
    bit one_wins, two_wins;
    one_wins = r && !l && rm && !lm;
    two_wins = l && !r && lm && !rm;
    if (rs) begin
      m_started = 0; m_over = 0; m_hold_left = 0;
      m_s1 = 0; m_s2 = 0; m_last = 2'd0;
    end else if (!m_started) begin
      if (st) begin
        m_started = 1; m_s1 = 0; m_s2 = 0; m_last = 2'd0;
      end
    end else if (m_over) begin
      if (st) begin
        m_over = 0; m_s1 = 0; m_s2 = 0; m_last = 2'd0;
      end
    end else if (m_hold_left > 0) begin
      m_hold_left--;
      if (m_hold_left == 0) m_last = 2'd0;
    end else if (st) begin
      m_s1 = 0; m_s2 = 0; m_last = 2'd0;
    end else if (one_wins || two_wins) begin
      if (one_wins) begin
        m_s1++; m_last = 2'd1;
      end else begin
        m_s2++; m_last = 2'd2;
      end
      if (m_s1 == WIN_TARGET || m_s2 == WIN_TARGET) m_over = 1;
      else m_hold_left = HOLD_CYCLES;
    end
    e.pe = m_started && !m_over && (m_hold_left == 0);
    e.fr = !e.pe;
    e.mo = m_over;
    e.rw = m_last;
    e.h1 = digit(m_s1);
    e.h2 = digit(m_s2);
    e.hw = (m_last == 2'd1) ? 7'b1111001 : (m_last == 2'd2) ? 7'b0100100 : 7'b1111111;
    sb.push_back(e);
  endtask

  task automatic applyStimulus(input bit rs, input bit st, input bit l, input bit r,
                               input bit lm, input bit rm);
    @(negedge clk);
    reset = rs; start = st; L = l; R = r; lmost = lm; rmost = rm;
    modelStep(rs, st, l, r, lm, rm);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0);
  endtask

  task automatic p1Win();
    applyStimulus(0, 0, 0, 1, 0, 1);
  endtask

  task automatic p2Win();
    applyStimulus(0, 0, 1, 0, 1, 0);
  endtask

  // Monitor: compare every cycle that has a queued prediction
  always @(posedge clk) begin
    cycle++;
    #1;
    if (sb.size() > 0) begin
      got = sb.pop_front();
      checkOutput("field_reset", {6'd0, field_reset}, {6'd0, got.fr});
      checkOutput("press_en", {6'd0, press_en}, {6'd0, got.pe});
      checkOutput("match_over", {6'd0, match_over}, {6'd0, got.mo});
      checkOutput("round_winner", {5'd0, round_winner}, {5'd0, got.rw});
      checkOutput("hex_p1", hex_p1, got.h1);
      checkOutput("hex_p2", hex_p2, got.h2);
      checkOutput("hex_win", hex_win, got.hw);
    end
  end

  initial begin
    int sel;
    reset = 1; start = 0; L = 0; R = 0; lmost = 0; rmost = 0;
    $display("[TB] directed sequences");
    // Reset, idle, start
    applyStimulus(1, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0);
    idle(2);
    applyStimulus(0, 1, 0, 0, 0, 0);
    idle(1);
    // Player 1 round win and full hold interval
    p1Win();
    idle(6);
    // Contradictory presses and both ends lit
    applyStimulus(0, 0, 1, 1, 1, 0);
    applyStimulus(0, 0, 0, 1, 1, 1);
    idle(1);
    // Three player 2 wins end the match; presses ignored in OVER
    for (int k = 0; k < 3; k++) begin
      p2Win();
      idle(HOLD_CYCLES + 1);
    end
    p2Win();
    p1Win();
    applyStimulus(0, 0, 1, 1, 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 0);
    idle(2);
    // Reset in the middle of a hold
    p1Win();
    idle(2);
    applyStimulus(1, 0, 0, 0, 0, 0);
    idle(2);
    // Start beats a match-winning press
    applyStimulus(0, 1, 0, 0, 0, 0);
    p1Win();
    idle(HOLD_CYCLES + 1);
    p1Win();
    idle(HOLD_CYCLES + 1);
    applyStimulus(0, 1, 0, 1, 0, 1);
    idle(2);
    // Start ignored during hold
    p2Win();
    applyStimulus(0, 1, 0, 0, 0, 0);
    idle(HOLD_CYCLES + 1);

    $display("[TB] randomized sequences");
    for (int i = 0; i < 800; i++) begin
      sel = $urandom_range(0, 99);
      if (sel == 0)                    applyStimulus(1, 0, 0, 0, 0, 0);
      else if (sel <= 3)               applyStimulus(0, 1, $urandom_range(0, 1), $urandom_range(0, 1),
                                                     $urandom_range(0, 1), $urandom_range(0, 1));
      else if (sel <= 25)              p1Win();
      else if (sel <= 47)              p2Win();
      else                             applyStimulus(0, 0, $urandom_range(0, 1), $urandom_range(0, 1),
                                                     $urandom_range(0, 1), $urandom_range(0, 1));
    end
    idle(1);

    for (int k = 0; k < 10 && sb.size() > 0; k++) @(posedge clk);
    #2;
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("[TB] FAIL drain actual=%0d expected=0 pending predictions", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tow_match_ctrl.md
Name: tow_match_ctrl

Overview:
Round/match sequencer for the tug-of-war game. It watches the conditioned player presses and the two end-of-field lights, and detects round wins. It tallies per-player scores, re-centres the playfield between rounds through a hold interval, and declares the match winner at a target score. It sits above the playfield light chain and drives its reset, the press-enable gating and three HEX displays.

Parameters:
WIN_TARGET, 3, rounds needed to win the match (legal 1..9)
HOLD_CYCLES, 1024, cycles the round winner is shown with playfield held in reset (legal >= 1)
CW, 10, hold counter width; must satisfy 2**CW >= HOLD_CYCLES

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high
start  in  1  one-cycle pulse from conditioned KEY; begins or restarts match
L  in  1  player-2 (left) press, one-cycle pulse
R  in  1  player-1 (right) press, one-cycle pulse
lmost  in  1  leftmost field light lit
rmost  in  1  rightmost field light lit
field_reset  out  1  synchronous reset to playfield lights (centre light on)
press_en  out  1  gate for L/R into playfield; 1 only in PLAY
round_winner  out  2  0 none, 1 player 1, 2 player 2 (last round)
match_over  out  1  high in OVER
hex_p1  out  7  active-low 7-seg of player-1 score
hex_p2  out  7  active-low 7-seg of player-2 score
hex_win  out  7  active-low: "1"=1111001, "2"=0100100, blank=1111111

Behaviour:
- One clock: clk. Reset is synchronous and active-high.
- States: IDLE, PLAY, HOLD, OVER. All state, scores, round_winner and counter are registered. Outputs decode from registers only: Moore, no combinational input-to-output path.
- Reset (any state, mid-hold included): state=IDLE, scores=0, round_winner=0, cnt=0. Outputs: field_reset=1, press_en=0, match_over=0, hex_p1/hex_p2 show "0", hex_win blank.
- Win events are qualified in PLAY only:
  - p1_win = R & ~L & rmost & ~lmost
  - p2_win = L & ~R & lmost & ~rmost
  - L&R together, or both ends lit: no event.
- IDLE: field_reset=1. When start=1, the next edge goes to PLAY with scores cleared.
- PLAY: field_reset=0, press_en=1.
  - On p1_win, the next edge does score1++ and round_winner=1.
  - On p2_win, the next edge does score2++ and round_winner=2.
  - If the incremented score == WIN_TARGET, go to OVER. Otherwise go to HOLD with cnt=HOLD_CYCLES-1.
  - start in PLAY restarts: scores=0, round_winner=0, stay PLAY.
- HOLD: field_reset=1, press_en=0, hex_win shows round_winner.
  - cnt decrements each cycle; at cnt==0 the next edge goes to PLAY and round_winner=0.
  - The hold interval lasts exactly HOLD_CYCLES cycles.
  - start in HOLD is ignored. Presses and end lights are ignored.
- OVER: field_reset=1, press_en=0, match_over=1. round_winner and scores are frozen; hex_win shows the match winner.
  - start goes to PLAY with scores=0 and round_winner=0.
  - L/R are ignored.
- Latency: win event at edge N is visible on outputs after edge N. field_reset asserts in the same cycle the new state is entered.
- Score counters are 4-bit and saturate at WIN_TARGET; the counter never wraps.
- hex_win is blank whenever round_winner==0.
- Simultaneous start and win in PLAY: start has priority, so no score is taken.
- Simultaneous reset and anything: reset has priority.

Decomposition:
- Package tow_pkg:
  - state enum (IDLE, PLAY, HOLD, OVER)
  - winner codes (NONE=0, P1=1, P2=2)
  - 7-seg constants SEG_BLANK, SEG_1, SEG_2
  - digit table 0..9
- One sub-module: seg7_digit, a 4-bit to active-low 7-seg decoder with values >9 shown blank. It is instanced for hex_p1 and hex_p2. hex_win uses the package constants directly.

Test Plan:
(Use WIN_TARGET=3, HOLD_CYCLES=4.)
1. Reset then start pulse -> IDLE outputs (field_reset=1, hex_p1=hex_p2=1000000); one cycle after start: PLAY, press_en=1, field_reset=0.
2. PLAY, R=1 rmost=1 lmost=0 L=0 for one cycle -> next cycle: score1=1, hex_p1=1111001, hex_win=1111001, field_reset=1 for exactly 4 cycles, then PLAY with hex_win=1111111.
3. PLAY, L=1 R=1 lmost=1 -> no score change, stays PLAY. Then R=1 with lmost=1 rmost=1 -> no score change.
4. Three p2 wins separated by hold intervals -> after the third: OVER, match_over=1, hex_p2=0110000, hex_win=0100100; further L/R pulses change nothing. start -> PLAY, scores 0, hex_win blank.
5. Assert reset 2 cycles into HOLD with score1=1 -> next cycle: IDLE, scores 0, field_reset=1, round_winner=0.
6. start and p1_win in the same PLAY cycle with score1=2 -> scores cleared to 0, state stays PLAY (not OVER).
